core_mem_arbiter: RTL
=====================

Name: core_mem_arbiter

Overview:
Shares one external memory port between the RISCY core's instruction-fetch and data-memory interfaces. All three interfaces use the req/gnt/rvalid protocol: the address phase is the req/gnt handshake, and the response phase is a single-cycle rvalid with responses returned in order. The block arbitrates address phases round-robin. It records the owner of every granted request in an in-order queue and routes each rvalid and its rdata back to that owner. It sits between the core and the unified memory model in the testbench.

Parameters:
MAX_OUTSTANDING, 2, maximum granted-but-unanswered requests; legal range 1..8.
ADDR_WIDTH, 32, address width of all ports.
DATA_WIDTH, 32, data width; byte-enable width is DATA_WIDTH/8.

Ports:
clk_i  in  1  clock; all state updates on the rising edge.
rst_i  in  1  reset, synchronous, active-high.
instr_req_i  in  1  fetch request.
instr_addr_i  in  ADDR_WIDTH  fetch address.
instr_gnt_o  out  1  fetch address phase accepted.
instr_rvalid_o  out  1  fetch response valid.
instr_rdata_o  out  DATA_WIDTH  fetch response data.
data_req_i  in  1  data request.
data_we_i  in  1  1 = write.
data_be_i  in  DATA_WIDTH/8  byte enables.
data_addr_i  in  ADDR_WIDTH  data address.
data_wdata_i  in  DATA_WIDTH  write data.
data_gnt_o  out  1  data address phase accepted.
data_rvalid_o  out  1  data response valid.
data_rdata_o  out  DATA_WIDTH  data response (read data).
mem_req_o  out  1  request to memory.
mem_we_o  out  1  write enable to memory.
mem_be_o  out  DATA_WIDTH/8  byte enables to memory.
mem_addr_o  out  ADDR_WIDTH  address to memory.
mem_wdata_o  out  DATA_WIDTH  write data to memory.
mem_gnt_i  in  1  memory accepted the address phase.
mem_rvalid_i  in  1  memory response valid.
mem_rdata_i  in  DATA_WIDTH  memory response data.
outstanding_o  out  4  current queue occupancy.
err_o  out  1  sticky protocol error.

Behaviour:
- Reset: while rst_i=1, every output is 0, including the combinational outputs. On reset the queue empties, the count goes to 0, lock clears, last_owner becomes INSTR and err_o clears. Reset mid-transaction drops all tracked requests.
- Address phase:
  - mem_req_o = (instr_req_i | data_req_i) & (count < MAX_OUTSTANDING) & ~rst_i.
  - The mem_* payload is taken from the selected owner.
  - Instruction payload is forced: we=0, be=all-ones, wdata=0.
  - The selected owner's gnt_o = mem_gnt_i & mem_req_o. The other gnt_o is 0.
  - mem_gnt_i, mem_rvalid_i and mem_rdata_i pass to owners combinationally. There is zero added latency on gnt and rvalid.
- Owner selection:
  - If lock=1, select the locked owner.
  - Else, if only one requester is active, select it.
  - Else, if both are active, select the one that is not last_owner.
- Lock:
  - Set when mem_req_o=1 and mem_gnt_i=0 at the clock edge; the current owner is held. This keeps the payload stable until the grant.
  - Cleared on the grant.
  - If the locked owner drops req before the grant (protocol violation), set err_o and clear the lock.
- On a grant (mem_req_o & mem_gnt_i):
  - Push the owner ID (1 bit) into the circular queue (wr_ptr wraps modulo MAX_OUTSTANDING).
  - Update last_owner.
- On mem_rvalid_i:
  - Pop the head (rd_ptr wraps modulo MAX_OUTSTANDING).
  - Pulse rvalid_o of the head owner for that cycle; rdata_o = mem_rdata_i for that owner.
  - The non-owner's rdata_o holds 0.
- Simultaneous push and pop in one cycle: count unchanged, both pointers advance.
- Queue full (count==MAX_OUTSTANDING): mem_req_o=0 even if a pop occurs in the same cycle. The request is re-presented the next cycle.
- mem_rvalid_i while count==0: set err_o, drop the response, leave pointers unchanged.
- err_o is sticky until reset.
- outstanding_o = count, zero-extended to 4 bits.

Test Plan:
- Reset, then a single fetch at 0x0000_0080 with gnt immediate and rvalid one cycle later, rdata 0x0000_0013. Required: instr_gnt_o and instr_rvalid_o each pulse once; instr_rdata_o=0x13; data_rvalid_o stays 0; outstanding_o goes 0→1→0.
- Both requesters active every cycle, mem_gnt_i=1, rvalid one cycle after each gnt. Required: grants alternate D,I,D,I, with data first after reset; each response is routed to the matching owner.
- Data write to addr 0x100, be=4'b0011, wdata 0xDEAD_BEEF, mem_gnt_i held 0 for 3 cycles. Meanwhile instr_req_i rises in cycle 2. Required: the mem_* payload stays on the data request for all 3 cycles; instr_gnt_o=0; the data grant happens on the 4th cycle.
- MAX_OUTSTANDING=2, three fetches with gnt immediate and rvalid withheld. Required: two grants, then mem_req_o=0 with outstanding_o=2. After one rvalid, the third request is granted in the following cycle.
- mem_rvalid_i pulse with an empty queue. Required: err_o=1 and stays 1; no rvalid_o pulse; next reset clears it.
- Reset asserted with 2 requests outstanding. Required: all outputs 0 during reset; outstanding_o=0 after reset.

Source files
------------

// File: rtl/core_mem_arbiter.sv
// core_mem_arbiter: round-robin share of one req/gnt/rvalid memory port between fetch and data,
// with an in-order owner queue that routes each response back to its requester.
module core_mem_arbiter #(
    parameter int unsigned MAX_OUTSTANDING = 2,
    parameter int unsigned ADDR_WIDTH      = 32,
    parameter int unsigned DATA_WIDTH      = 32
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    instr_req_i,
    input  logic [ADDR_WIDTH-1:0]   instr_addr_i,
    output logic                    instr_gnt_o,
    output logic                    instr_rvalid_o,
    output logic [DATA_WIDTH-1:0]   instr_rdata_o,
    input  logic                    data_req_i,
    input  logic                    data_we_i,
    input  logic [DATA_WIDTH/8-1:0] data_be_i,
    input  logic [ADDR_WIDTH-1:0]   data_addr_i,
    input  logic [DATA_WIDTH-1:0]   data_wdata_i,
    output logic                    data_gnt_o,
    output logic                    data_rvalid_o,
    output logic [DATA_WIDTH-1:0]   data_rdata_o,
    output logic                    mem_req_o,
    output logic                    mem_we_o,
    output logic [DATA_WIDTH/8-1:0] mem_be_o,
    output logic [ADDR_WIDTH-1:0]   mem_addr_o,
    output logic [DATA_WIDTH-1:0]   mem_wdata_o,
    input  logic                    mem_gnt_i,
    input  logic                    mem_rvalid_i,
    input  logic [DATA_WIDTH-1:0]   mem_rdata_i,
    output logic [3:0]              outstanding_o,
    output logic                    err_o
);
    localparam logic [3:0] MAXC  = 4'(MAX_OUTSTANDING);
    localparam logic [2:0] LASTP = 3'(MAX_OUTSTANDING - 1);
    logic [7:0] q_q, q_d;
    logic [2:0] wr_q, wr_d, rd_q, rd_d;
    logic [3:0] cnt_q, cnt_d;
    logic lock_q, lock_d, lown_q, lown_d, last_q, last_d, err_q, err_d;
    logic own_req, sel, req, gnt, pop, head, empty;
    // owner id: 0 = instruction fetch, 1 = data
    always_comb begin
        own_req = lown_q ? data_req_i : instr_req_i;
        sel     = (lock_q & own_req) ? lown_q : (instr_req_i & data_req_i) ? ~last_q : data_req_i;
        req     = (instr_req_i | data_req_i) & (cnt_q < MAXC) & ~rst_i;
        gnt     = req & mem_gnt_i;
        empty   = cnt_q == 4'd0;
        pop     = mem_rvalid_i & ~empty & ~rst_i;
        head    = q_q[rd_q];
        q_d     = q_q;
        if (gnt) q_d[wr_q] = sel;
        wr_d    = gnt ? ((wr_q == LASTP) ? 3'd0 : wr_q + 3'd1) : wr_q;
        rd_d    = pop ? ((rd_q == LASTP) ? 3'd0 : rd_q + 3'd1) : rd_q;
        cnt_d   = cnt_q + {3'd0, gnt} - {3'd0, pop};
        lock_d  = req & ~mem_gnt_i;
        lown_d  = sel;
        last_d  = gnt ? sel : last_q;
        // a locked owner withdrawing before its grant is a protocol violation
        err_d   = err_q | (mem_rvalid_i & empty) | (lock_q & ~own_req);
    end
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            q_q    <= '0;
            wr_q   <= '0;
            rd_q   <= '0;
            cnt_q  <= '0;
            lock_q <= 1'b0;
            lown_q <= 1'b0;
            last_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            q_q    <= q_d;
            wr_q   <= wr_d;
            rd_q   <= rd_d;
            cnt_q  <= cnt_d;
            lock_q <= lock_d;
            lown_q <= lown_d;
            last_q <= last_d;
            err_q  <= err_d;
        end
    end
    assign mem_req_o      = req;
    assign mem_we_o       = ~rst_i & sel & data_we_i;
    assign mem_be_o       = rst_i ? '0 : sel ? data_be_i : '1;
    assign mem_addr_o     = rst_i ? '0 : sel ? data_addr_i : instr_addr_i;
    assign mem_wdata_o    = (rst_i | ~sel) ? '0 : data_wdata_i;
    assign instr_gnt_o    = gnt & ~sel;
    assign data_gnt_o     = gnt & sel;
    assign instr_rvalid_o = pop & ~head;
    assign data_rvalid_o  = pop & head;
    assign instr_rdata_o  = instr_rvalid_o ? mem_rdata_i : '0;
    assign data_rdata_o   = data_rvalid_o ? mem_rdata_i : '0;
    assign outstanding_o  = rst_i ? 4'd0 : cnt_q;
    assign err_o          = err_q & ~rst_i;
endmodule
